// File: rtl/button_ctrl_pkg.sv
// Shared types for the board button conditioning block.
package button_ctrl_pkg;

  typedef enum logic [1:0] {
    StAssert,
    StHold,
    StRun
  } rst_state_e;

endpackage

// File: rtl/button_debounce.sv
// One button channel: two-flop synchroniser, stability counter and registered
// falling-edge pulse on the accepted level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk25,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_dly_q, level_dly_d;
  logic            press_q, press_d;
  logic            s;

  assign s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], raw};
    level_d     = level_q;
    cnt_d       = cnt_q;
    level_dly_d = level_q;
    // Pulse lands the cycle after the accepted fall, never on release.
    press_d     = level_dly_q & ~level_q;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/button_ctrl.sv
// Debounces the board buttons and derives the core reset, clear-screen strobe
// and the persistent PS/2/UART input-select flag. RESET_HOLD must be >= 2.
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned RESET_HOLD      = 16
) (
  input  logic                   clk25,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic                   sys_rst_n,
  output logic                   cls,
  output logic                   ps2_select
);

  localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk25(clk25),
      .rst  (rst),
      .raw  (button[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  rst_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             ps2_q, ps2_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    unique case (state_q)
      StAssert: begin
        if (btn_level[0]) state_d = StHold;
      end
      StHold: begin
        if (!btn_level[0]) begin
          state_d = StAssert;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (hold_cnt_d == HoldLast) state_d = StRun;
        end
      end
      StRun: begin
        if (!btn_level[0]) state_d = StAssert;
      end
      default: state_d = StAssert;
    endcase
  end

  // Reset asserts in the same cycle the button level is accepted low.
  assign sys_rst_n = (state_q == StRun) && btn_level[0];
  assign cls       = btn_press[1] & sys_rst_n;

  always_comb begin
    ps2_d = ps2_q;
    if (btn_press[2] && sys_rst_n) ps2_d = ~ps2_q;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q    <= StAssert;
      hold_cnt_q <= '0;
      ps2_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ps2_q      <= ps2_d;
    end
  end

  assign ps2_select = ps2_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor
// turns observed output changes into events and checks them in order.
module tb_button_ctrl;

  localparam int EvLevel = 0;
  localparam int EvPress = 1;
  localparam int EvCls   = 2;
  localparam int EvRstN  = 3;
  localparam int EvPs2   = 4;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] btn_level, btn_press;
  logic       sys_rst_n, cls, ps2_select;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  done = 1'b0;
  bit  first = 1'b1;
  ev_t exp_q[$];

  logic [3:0] prev_level;
  logic       prev_rst_n, prev_ps2;

  button_ctrl #(
    .NUM_BUTTONS    (4),
    .DEBOUNCE_CYCLES(8),
    .RESET_HOLD     (4)
  ) dut (
    .clk25     (clk),
    .rst       (rst),
    .button    (btn),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .sys_rst_n (sys_rst_n),
    .cls       (cls),
    .ps2_select(ps2_select)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int kind);
    case (kind)
      EvLevel: return "btn_level";
      EvPress: return "btn_press";
      EvCls:   return "cls";
      EvRstN:  return "sys_rst_n";
      default: return "ps2_select";
    endcase
  endfunction

  task automatic expect_ev(input int c, input int kind, input logic [3:0] v);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [3:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s: cycle %0d value %b, nothing expected",
               ev_name(kind), cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val !== v) begin
        errors++;
        $display("FAIL %s: got cycle %0d value %b, expected %s at cycle %0d value %b",
                 ev_name(kind), cyc, v, ev_name(e.kind), e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      while (exp_q.size() > 0) begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing %s: never seen, expected cycle %0d value %b",
                 ev_name(e.kind), e.cyc, e.val);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (mon_en) begin
      if (first || btn_level !== prev_level) check_ev(EvLevel, btn_level);
      if (first || btn_press != 4'b0000) check_ev(EvPress, btn_press);
      if (first || cls) check_ev(EvCls, {3'b000, cls});
      if (first || sys_rst_n !== prev_rst_n) check_ev(EvRstN, {3'b000, sys_rst_n});
      if (first || ps2_select !== prev_ps2) check_ev(EvPs2, {3'b000, ps2_select});
      prev_level = btn_level;
      prev_rst_n = sys_rst_n;
      prev_ps2   = ps2_select;
      first      = 1'b0;
    end
  end

  // Returns 1 time unit after posedge number c, so a change made here is
  // first sampled at edge c+1; level follows at c+10, pulses at c+11.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    btn = 4'b1111;
    rst = 1'b1;
    wait_until(3);
    rst    = 1'b0;
    mon_en = 1'b1;
    // Reset defaults, then release 4 cycles after rst drops
    expect_ev(3, EvLevel, 4'b1111);
    expect_ev(3, EvPress, 4'b0000);
    expect_ev(3, EvCls,   4'b0000);
    expect_ev(3, EvRstN,  4'b0000);
    expect_ev(3, EvPs2,   4'b0001);
    expect_ev(7, EvRstN,  4'b0001);

    // Glitch: 5 cycles low is shorter than the debounce window
    wait_until(10);  btn[1] = 1'b0;
    wait_until(15);  btn[1] = 1'b1;

    // Clean press and release of button 1
    wait_until(30);  btn[1] = 1'b0;
    expect_ev(40, EvLevel, 4'b1101);
    expect_ev(41, EvPress, 4'b0010);
    expect_ev(41, EvCls,   4'b0001);
    wait_until(50);  btn[1] = 1'b1;
    expect_ev(60, EvLevel, 4'b1111);

    // Two toggles of ps2_select
    wait_until(70);  btn[2] = 1'b0;
    expect_ev(80, EvLevel, 4'b1011);
    expect_ev(81, EvPress, 4'b0100);
    expect_ev(82, EvPs2,   4'b0000);
    wait_until(90);  btn[2] = 1'b1;
    expect_ev(100, EvLevel, 4'b1111);
    wait_until(110); btn[2] = 1'b0;
    expect_ev(120, EvLevel, 4'b1011);
    expect_ev(121, EvPress, 4'b0100);
    expect_ev(122, EvPs2,   4'b0001);
    wait_until(130); btn[2] = 1'b1;
    expect_ev(140, EvLevel, 4'b1111);

    // Button reset held 20 cycles; button 2 press inside it must not toggle
    wait_until(150); btn[0] = 1'b0;
    expect_ev(160, EvLevel, 4'b1110);
    expect_ev(160, EvRstN,  4'b0000);
    expect_ev(161, EvPress, 4'b0001);
    wait_until(155); btn[2] = 1'b0;
    expect_ev(165, EvLevel, 4'b1010);
    expect_ev(166, EvPress, 4'b0100);
    wait_until(165); btn[2] = 1'b1;
    expect_ev(175, EvLevel, 4'b1110);
    wait_until(170); btn[0] = 1'b1;
    expect_ev(180, EvLevel, 4'b1111);
    expect_ev(184, EvRstN,  4'b0001);

    // Simultaneous presses on buttons 1 and 3
    wait_until(200); btn = 4'b0101;
    expect_ev(210, EvLevel, 4'b0101);
    expect_ev(211, EvPress, 4'b1010);
    expect_ev(211, EvCls,   4'b0001);
    wait_until(220); btn = 4'b1111;
    expect_ev(230, EvLevel, 4'b1111);

    wait_until(250);
    done = 1'b1;
  end

endmodule
